// File: rtl/core_seq_pkg.sv
// Shared definitions for the d16 core sequencer: state encodings and PC step.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_seq_pkg;

   typedef enum logic [2:0] {
      SEQ_FETCH  = 3'd0,
      SEQ_DECODE = 3'd1,
      SEQ_IMM    = 3'd2,
      SEQ_ALU    = 3'd3,
      SEQ_MEM    = 3'd4,
      SEQ_WB     = 3'd5,
      SEQ_FAULT  = 3'd6
   } seq_state_t;

   // Instructions and immediates are one 16-bit word, i.e. two bytes.
   localparam int unsigned PC_INC = 2;

   // States that own a memory transfer.
   function automatic logic is_bus_state(input seq_state_t s);
      return (s == SEQ_FETCH) || (s == SEQ_IMM) || (s == SEQ_MEM);
   endfunction

endpackage

// File: rtl/core_seq_bus.sv
// Memory request engine: holds mem_req with a latched command until mem_ack, flags a timeout.
// Latency: request issued the cycle after start; done/err are combinational in the final req cycle.
// Backpressure: mem_ack gates completion; MEM_TIMEOUT unacked req cycles abort the transfer.
// Ports: start + cmd_* (command, sampled only when idle), mem_* (memory side),
//        done (ack accepted this cycle), err (timeout reached this cycle).
module core_seq_bus #(
   parameter int ADDR_W      = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-2:0] cmd_addr,
   input  logic              cmd_we,
   input  logic              cmd_byte,
   input  logic              cmd_byte_sel,
   input  logic              mem_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic              mem_byte,
   output logic              mem_byte_sel,
   output logic [ADDR_W-2:0] mem_addr,
   output logic              done,
   output logic              err
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   logic [CNT_W-1:0] wait_cnt;

   assign done = mem_req && mem_ack;
   // wait_cnt counts completed unacked cycles, so the current one is number wait_cnt+1.
   assign err  = mem_req && !mem_ack && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_byte     <= 1'b0;
         mem_byte_sel <= 1'b0;
         mem_addr     <= '0;
         wait_cnt     <= '0;
      end else if (mem_req) begin
         if (done || err) begin
            mem_req  <= 1'b0;
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end else if (start) begin
         // Command is latched so address/strobes cannot move while req is up.
         mem_req      <= 1'b1;
         mem_addr     <= cmd_addr;
         mem_we       <= cmd_we;
         mem_byte     <= cmd_byte;
         mem_byte_sel <= cmd_byte_sel;
         wait_cnt     <= '0;
      end
   end

endmodule

// File: rtl/core_seq.sv
// Multi-cycle sequencer for the d16 core: FSM, PC, IR, immediate, load data and memory handshake.
// Latency: FETCH/IMM/MEM take 1 idle cycle + req cycles until ack; DECODE, ALU, WB one cycle each.
// Backpressure: stalls in bus states until mem_ack; MEM_TIMEOUT unacked cycles -> sticky FAULT.
// Ports: clk/rst_n (sync, active-low); mem_* memory req/ack bus; ir/imm/load_data/pc registers;
//        en_decode/en_alu/en_reg_wr stage pulses; dec_* and alu_* from decoder/ALU; bus_err sticky.
// Option: define CORE_SEQ_IRQ_EN to add irq/dec_reti/irq_ack with ie/epc interrupt entry/return.
module core_seq
   import core_seq_pkg::*;
#(
   parameter int          DATA_W      = 16,
   parameter int          ADDR_W      = 16,
   parameter int unsigned RESET_PC    = 0,
   parameter int          MEM_TIMEOUT = 15
`ifdef CORE_SEQ_IRQ_EN
   ,
   parameter int unsigned IRQ_VECTOR  = 16'h0004
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_req,
   output logic              mem_we,
   output logic              mem_byte,
   output logic              mem_byte_sel,
   output logic [ADDR_W-2:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [DATA_W-1:0] ir,
   output logic [DATA_W-1:0] imm,
   output logic              en_decode,
   output logic              en_alu,
   output logic              en_reg_wr,
   input  logic              dec_en_mem,
   input  logic              dec_is_store,
   input  logic              dec_mem_byte,
   input  logic [ADDR_W-1:0] alu_result,
   input  logic              alu_branch,
   output logic [DATA_W-1:0] load_data,
   output logic [ADDR_W-1:0] pc,
   output logic              bus_err
`ifdef CORE_SEQ_IRQ_EN
   ,
   input  logic              irq,
   input  logic              dec_reti,
   output logic              irq_ack
`endif
);

   seq_state_t        state;
   seq_state_t        state_nxt;

   logic              acc_vld;
   logic [ADDR_W-2:0] acc_addr;
   logic              acc_we;
   logic              acc_byte;
   logic              acc_sel;
   logic              bus_done;
   logic              bus_to;

   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_wb;

`ifdef CORE_SEQ_IRQ_EN
   logic              ie;
   logic [ADDR_W-1:0] epc;
`endif

   assign acc_vld = is_bus_state(state);
   assign pc_inc  = pc + ADDR_W'(PC_INC);
   // Branch targets are word aligned; the ALU's bit 0 is dropped.
   assign pc_wb   = alu_branch ? {alu_result[ADDR_W-1:1], 1'b0} : pc;

   core_seq_bus #(
      .ADDR_W      (ADDR_W),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_bus (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (acc_vld),
      .cmd_addr     (acc_addr),
      .cmd_we       (acc_we),
      .cmd_byte     (acc_byte),
      .cmd_byte_sel (acc_sel),
      .mem_ack      (mem_ack),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_byte     (mem_byte),
      .mem_byte_sel (mem_byte_sel),
      .mem_addr     (mem_addr),
      .done         (bus_done),
      .err          (bus_to)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= SEQ_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      en_decode = 1'b0;
      en_alu    = 1'b0;
      en_reg_wr = 1'b0;
      acc_addr  = pc[ADDR_W-1:1];
      acc_we    = 1'b0;
      acc_byte  = 1'b0;
      acc_sel   = pc[0];
      case (state)
         SEQ_FETCH: begin
            if (bus_done) state_nxt = SEQ_DECODE;
         end
         SEQ_DECODE: begin
            en_decode = 1'b1;
            state_nxt = ir[15] ? SEQ_IMM : SEQ_ALU;
         end
         SEQ_IMM: begin
            if (bus_done) state_nxt = SEQ_ALU;
         end
         SEQ_ALU: begin
            en_alu    = 1'b1;
            state_nxt = dec_en_mem ? SEQ_MEM : SEQ_WB;
         end
         SEQ_MEM: begin
            acc_addr = alu_result[ADDR_W-1:1];
            acc_sel  = alu_result[0];
            acc_we   = dec_is_store;
            acc_byte = dec_mem_byte;
            if (bus_done) state_nxt = SEQ_WB;
         end
         SEQ_WB: begin
            en_reg_wr = 1'b1;
            state_nxt = SEQ_FETCH;
         end
         default: begin
            state_nxt = SEQ_FAULT;
         end
      endcase
      if (bus_to) state_nxt = SEQ_FAULT;
   end

`ifdef CORE_SEQ_IRQ_EN
   // Return-from-interrupt wins over a pending irq in the same WB.
   assign irq_ack = (state == SEQ_WB) && irq && ie && !dec_reti;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc        <= ADDR_W'(RESET_PC);
         ir        <= '0;
         imm       <= '0;
         load_data <= '0;
         bus_err   <= 1'b0;
`ifdef CORE_SEQ_IRQ_EN
         ie        <= 1'b1;
         epc       <= '0;
`endif
      end else begin
         if (bus_to) bus_err <= 1'b1;
         case (state)
            SEQ_FETCH: begin
               if (bus_done) begin
                  ir <= mem_rdata;
                  pc <= pc_inc;
               end
            end
            SEQ_IMM: begin
               if (bus_done) begin
                  imm <= mem_rdata;
                  pc  <= pc_inc;
               end
            end
            SEQ_MEM: begin
               // mem_we is the latched strobe, so a store never disturbs load_data.
               if (bus_done && !mem_we) load_data <= mem_rdata;
            end
            SEQ_WB: begin
`ifdef CORE_SEQ_IRQ_EN
               if (dec_reti) begin
                  pc <= epc;
                  ie <= 1'b1;
               end else if (irq && ie) begin
                  epc <= pc_wb;
                  pc  <= ADDR_W'(IRQ_VECTOR);
                  ie  <= 1'b0;
               end else begin
                  pc <= pc_wb;
               end
`else
               pc <= pc_wb;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
